// File: rtl/semaforo_pantalla_n.sv
`default_nettype none
// ============================================================================
//  Module   : semaforo_pantalla_n
//  Purpose  : Two-stage pipelined pixel renderer for N traffic lights on the
//             VGA path. Lamp states are latched once per frame into shadow
//             registers, and lamps can optionally blink.
//  Build    : define SEMAFORO_BLINK_EN to include the per-lamp blink logic
//             (blink counter, blink phase, lamp_blink shadow). Without it,
//             lamp_blink is ignored and a lamp is lit when its shadow_on bit
//             is set.
//  Ports    : clk          - system clock
//             reset        - synchronous, active-high
//             x, y         - pixel column / row (10 bit)
//             pix_valid    - x/y valid this cycle
//             frame_start  - one-cycle pulse per frame; latches lamp inputs
//                            and advances the blink counter
//             lamp_on      - per light i: [3i] green, [3i+1] amber, [3i+2] red
//             lamp_blink   - same layout; blink enable per lamp
//             R, G, B      - pixel colour, held while no pixel is in flight
//             rgb_valid    - pix_valid delayed by two cycles
//  Revision : 1.0 - initial release
// ============================================================================
module semaforo_pantalla_n #(
    parameter int N_SEM        = 2,
    parameter int X0           = 60,
    parameter int Y0           = 120,
    parameter int PITCH        = 380,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [3*N_SEM-1:0] lamp_on,
    input  logic [3*N_SEM-1:0] lamp_blink,
    output logic               R,
    output logic               G,
    output logic               B,
    output logic               rgb_valid
);

    // Bounds are evaluated in full integer precision and saturated at 1024:
    // a 10-bit coordinate can never reach such a bound, so it never matches
    // and nothing wraps around.
    function automatic logic [10:0] bound(input int v);
        return (v >= 1024) ? 11'd1024 : v[10:0];
    endfunction

    // ------------------------------------------------------------------
    // Shadow lamp state and blink
    // ------------------------------------------------------------------
    logic [3*N_SEM-1:0] shadow_on_q, shadow_on_d;
    logic [3*N_SEM-1:0] w_lit;

    assign shadow_on_d = frame_start ? lamp_on : shadow_on_q;

`ifdef SEMAFORO_BLINK_EN
    localparam int          CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    logic [3*N_SEM-1:0] shadow_blink_q, shadow_blink_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    always_comb begin
        shadow_blink_d = shadow_blink_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        if (frame_start) begin
            shadow_blink_d = lamp_blink;
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_blink_q <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
        end else begin
            shadow_blink_q <= shadow_blink_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
        end
    end

    assign w_lit = shadow_on_q & (~shadow_blink_q | {3*N_SEM{blink_phase_q}});
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_lamp_blink;
    assign unused_lamp_blink = ^lamp_blink;
    assign w_lit = shadow_on_q;
`endif

    // ------------------------------------------------------------------
    // Geometry: per-light hit detection
    // ------------------------------------------------------------------
    logic [10:0]           w_x, w_y;
    logic [N_SEM-1:0]      w_house;     // inside the housing
    logic [N_SEM-1:0]      w_inner;     // inside the housing, off the border
    logic [N_SEM-1:0][2:0] w_lit_hit;   // [j]: lamp j (0 red) hit and lit

    assign w_x = {1'b0, x};
    assign w_y = {1'b0, y};

    for (genvar i = 0; i < N_SEM; i++) begin : g_light
        localparam int          HX    = X0 + i * PITCH;
        localparam logic [10:0] HX_LO = bound(HX);
        localparam logic [10:0] HX_HI = bound(HX + 80);
        localparam logic [10:0] IX_LO = bound(HX + 2);
        localparam logic [10:0] IX_HI = bound(HX + 78);
        localparam logic [10:0] LX_LO = bound(HX + 10);
        localparam logic [10:0] LX_HI = bound(HX + 70);
        localparam logic [10:0] HY_LO = bound(Y0);
        localparam logic [10:0] HY_HI = bound(Y0 + 240);
        localparam logic [10:0] IY_LO = bound(Y0 + 2);
        localparam logic [10:0] IY_HI = bound(Y0 + 238);

        logic w_lamp_col;

        assign w_house[i] = (w_x >= HX_LO) && (w_x < HX_HI) &&
                            (w_y >= HY_LO) && (w_y < HY_HI);
        assign w_inner[i] = (w_x >= IX_LO) && (w_x < IX_HI) &&
                            (w_y >= IY_LO) && (w_y < IY_HI);
        assign w_lamp_col = (w_x >= LX_LO) && (w_x < LX_HI);

        for (genvar j = 0; j < 3; j++) begin : g_lamp
            localparam logic [10:0] LY_LO = bound(Y0 + 15 + 75 * j);
            localparam logic [10:0] LY_HI = bound(Y0 + 75 + 75 * j);
            // Lamp j counts from the top (red) while lamp bits count from
            // green, hence the reversed bit index.
            assign w_lit_hit[i][j] = w_lamp_col && (w_y >= LY_LO) &&
                                     (w_y < LY_HI) && w_lit[3*i + 2 - j];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: registered hit vectors
    // ------------------------------------------------------------------
    logic                  s1_valid_q,  s1_valid_d;
    logic [N_SEM-1:0][2:0] s1_lit_q,    s1_lit_d;
    logic [N_SEM-1:0]      s1_border_q, s1_border_d;
    logic [N_SEM-1:0]      s1_body_q,   s1_body_d;

    always_comb begin
        s1_valid_d  = pix_valid;
        s1_lit_d    = w_lit_hit;
        s1_border_d = w_house & ~w_inner;
        s1_body_d   = w_inner;
    end

    // ------------------------------------------------------------------
    // Stage 2: priority encode and colour
    // ------------------------------------------------------------------
    logic [2:0] rgb_q, rgb_d;
    logic       rgb_valid_q, rgb_valid_d;

    always_comb begin
        rgb_d       = rgb_q;
        rgb_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            rgb_d = 3'b001;
            // Walk from the highest index down so the lowest index wins.
            for (int i = N_SEM - 1; i >= 0; i--) begin
                if (s1_border_q[i] || s1_body_q[i]) begin
                    if (s1_lit_q[i][0])      rgb_d = 3'b100;
                    else if (s1_lit_q[i][1]) rgb_d = 3'b110;
                    else if (s1_lit_q[i][2]) rgb_d = 3'b010;
                    else if (s1_border_q[i]) rgb_d = 3'b111;
                    else                     rgb_d = 3'b000;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_on_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_lit_q    <= '0;
            s1_border_q <= '0;
            s1_body_q   <= '0;
            rgb_q       <= 3'b000;
            rgb_valid_q <= 1'b0;
        end else begin
            shadow_on_q <= shadow_on_d;
            s1_valid_q  <= s1_valid_d;
            s1_lit_q    <= s1_lit_d;
            s1_border_q <= s1_border_d;
            s1_body_q   <= s1_body_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign R         = rgb_q[2];
    assign G         = rgb_q[1];
    assign B         = rgb_q[0];
    assign rgb_valid = rgb_valid_q;

endmodule
`default_nettype wire
